fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage, directly downstream of the instruction memory.
//  - Drives the memory byte address and samples the returned byte.
//  - Assembles 1-3 byte instructions: opcode, operand lo, operand hi.
//  - Hands each complete instruction to decode over a valid/ready port, through a 1-entry output buffer.
//  - Honours branch/jump redirects from execute.
// PARAMETERS
//  PC_W    8  program counter / memory address width
//  DATA_W  8  instruction byte width
// PORTS
//  clka            in   1       single clock; all state updates on posedge
//  restart_n       in   1       synchronous active-low reset
//  run             in   1       fetch enable; high once program load is complete
//  mem_addr        out  PC_W    byte address to instruction memory (pc_in)
//  mem_data        in   DATA_W  byte returned by instruction memory, combinational from mem_addr
//  redirect_valid  in   1       load a new PC this cycle (taken branch/jump)
//  redirect_pc     in   PC_W    redirect target address
//  out_valid       out  1       buffered instruction available
//  out_ready       in   1       decode accepts the instruction when valid&&ready
//  out_opcode      out  DATA_W  opcode byte
//  out_op_lo       out  DATA_W  first operand byte (0 if len<2)
//  out_op_hi       out  DATA_W  second operand byte (0 if len<3)
//  out_len         out  2       instruction length in bytes, 1..3
//  out_pc          out  PC_W    address of the opcode byte
//  out_illegal     out  1       opcode[1:0]==2'b11 (reserved encoding)
// BEHAVIOUR
//  - Reset (restart_n=0 at posedge), wins over everything else:
//    - pc=0, state=IDLE, out_valid=0.
//    - out_opcode/op_lo/op_hi/len/pc/illegal=0, mem_addr=0.
//  - mem_addr = pc register, always.
//  - One byte is fetched per cycle: mem_data is sampled at the posedge ending the cycle.
//  - Length rule, on opcode[1:0]:
//    - 00 -> 1
//    - 01 -> 2
//    - 10 -> 3
//    - 11 -> 1 with illegal=1
//  - FSM states:
//    - IDLE: run=1 -> OPC.
//    - OPC: latch opcode and opc_pc=pc, pc<=pc+1. Len 1 -> complete; else -> OP1.
//    - OP1: latch op_lo, pc<=pc+1. Len 2 -> complete; else -> OP2.
//    - OP2: latch op_hi, pc<=pc+1 -> complete.
//    - HOLD: assembled instruction waiting for buffer space; pc does not advance.
//  - Complete: write the buffer if it is empty or being drained this cycle (out_valid&&out_ready).
//    - Then -> OPC if run=1, else IDLE.
//    - Otherwise (buffer full, not draining) -> HOLD.
//    - HOLD exits the edge the buffer drains, writing the buffer that same edge.
//  - Throughput: back-to-back 1-byte instructions with out_ready=1 give one instruction per cycle.
//  - Buffer: out_* stay stable while out_valid=1 and out_ready=0. Accept clears out_valid unless refilled that edge.
//  - Redirect has priority over fetch and handshake:
//    - pc<=redirect_pc; partial assembly and HOLD contents discarded.
//    - out_valid<=0, even if decode accepts the same cycle.
//    - Next state: OPC if run=1, else IDLE.
//  - run=0: next edge -> IDLE.
//    - Partial instruction discarded; pc rewinds to opc_pc so the instruction is refetched.
//    - Buffered entry retained.
//  - pc arithmetic is modulo 2^PC_W: 0xFF+1=0x00. Instructions straddling 0xFF/0x00 are legal.
//    Memory decodes only low address bits; aliasing is the memory's concern.
//  - Redirect and reset in the same cycle: reset wins.
// STRUCTURE
//  - Shared package cpu_pkg:
//    - state encodings (IDLE/OPC/OP1/OP2/HOLD)
//    - PC_W/DATA_W defaults
//    - LEN_* constants
//    - function inst_len(opcode) -> {illegal,len}, reused by decode
//  - One sub-module, fetch_out_buf: 1-entry valid/ready register slice with flush input.
// TESTING
//  1. Reset: restart_n=0 two cycles -> mem_addr=0, out_valid=0, all out_* 0; release with run=0 -> stays IDLE.
//  2. Mem {0x00:0x04,0x01:0x05,0x02:0xAA,0x03:0x06,0x04:0x34,0x05:0x12}, run=1, ready=1:
//     - {op 0x04, len1, pc0}
//     - {0x05, lo 0xAA, len2, pc1}
//     - {0x06, 34, 12, len3, pc3}
//     - mem_addr 0..5 on consecutive cycles.
//  3. Backpressure: out_ready=0 after first valid -> out_* stable, FSM reaches HOLD, pc frozen;
//     ready=1 -> next instruction valid one cycle later, none lost or duplicated.
//  4. Redirect mid-assembly (in OP1 of 3-byte op at pc 3), redirect_pc=0x10 -> out_valid=0,
//     next mem_addr=0x10, no partial instruction emitted.
//  5. Wrap: redirect_pc=0xFE, 3-byte opcode there -> mem_addr FE,FF,00, out_pc=0xFE.
//  6. Illegal opcode 0x07 -> len=1, out_illegal=1; run dropped in OP1 -> refetch from opcode address on resume.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by fetch and decode.
//  - default address/data widths
//  - instruction length constants and the opcode length rule
//  - fetch FSM state encoding
package cpu_pkg;

    localparam int DEF_PC_W   = 8;
    localparam int DEF_DATA_W = 8;

    localparam logic [1:0] LEN_1 = 2'd1;
    localparam logic [1:0] LEN_2 = 2'd2;
    localparam logic [1:0] LEN_3 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OPC  = 3'd1,
        ST_OP1  = 3'd2,
        ST_OP2  = 3'd3,
        ST_HOLD = 3'd4
    } fetch_state_t;

    // Length rule from the two low opcode bits. Returns {illegal, len}.
    // Encoding 11 is reserved: treated as a 1-byte instruction and flagged.
    function automatic logic [2:0] inst_len(input logic [1:0] enc);
        case (enc)
            2'b00:   return {1'b0, LEN_1};
            2'b01:   return {1'b0, LEN_2};
            2'b10:   return {1'b0, LEN_3};
            default: return {1'b1, LEN_1};
        endcase
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory port, redirect input from
// execute, and the valid/ready instruction port towards decode.
//  master : the fetch unit side
//  slave  : the environment side (memory, execute, decode)
interface fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [PC_W-1:0]   mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_opcode;
    logic [DATA_W-1:0] out_op_lo;
    logic [DATA_W-1:0] out_op_hi;
    logic [1:0]        out_len;
    logic [PC_W-1:0]   out_pc;
    logic              out_illegal;

    modport master (
        output mem_addr,
        input  mem_data,
        input  redirect_valid, redirect_pc,
        output out_valid,
        input  out_ready,
        output out_opcode, out_op_lo, out_op_hi, out_len, out_pc, out_illegal
    );

    modport slave (
        input  mem_addr,
        output mem_data,
        output redirect_valid, redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_opcode, out_op_lo, out_op_hi, out_len, out_pc, out_illegal
    );

endinterface

// File: rtl/fetch_out_buf.sv
// One-entry valid/ready register slice with flush.
//  clk, rst_n   : clock, synchronous active-low reset
//  flush        : drop the held entry (wins over write and accept)
//  in_valid     : write request; taken when in_ready
//  in_ready     : slot empty, or being drained this cycle
//  in_data      : entry to store
//  out_valid    : entry held
//  out_ready    : consumer accepts when out_valid && out_ready
//  out_data     : held entry, stable while out_valid && !out_ready
module fetch_out_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            // Even a same-cycle accept is discarded by a flush.
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
//  clka       : clock
//  restart_n  : synchronous active-low reset
//  run        : fetch enable
//  bus        : memory port (mem_addr/mem_data), redirect from execute,
//               buffered valid/ready instruction port to decode
// One byte is fetched per cycle from mem_addr (= pc). Instructions of
// 1..3 bytes are assembled and written into a 1-entry output buffer.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic         clka,
    input  logic         restart_n,
    input  logic         run,
    fetch_unit_if.master bus
);

    typedef struct packed {
        logic              illegal;
        logic [1:0]        len;
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] op_hi;
        logic [DATA_W-1:0] op_lo;
        logic [DATA_W-1:0] opcode;
    } inst_t;

    fetch_state_t      state;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   opc_pc;
    logic [DATA_W-1:0] opcode_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] hi_q;

    logic [DATA_W-1:0] cur_op;
    logic              cur_illegal;
    logic [1:0]        cur_len;
    logic              done;
    logic              buf_wr;
    logic              buf_space;
    inst_t             asm_inst;
    inst_t             buf_inst;

    assign bus.mem_addr = pc;

    // In OPC the opcode is still on the memory bus; afterwards it is latched.
    assign cur_op                 = (state == ST_OPC) ? bus.mem_data : opcode_q;
    assign {cur_illegal, cur_len} = inst_len(cur_op[1:0]);

    // The byte arriving this cycle completes the instruction (or it is
    // already complete and waiting in HOLD).
    assign done = (state == ST_OPC  && cur_len == LEN_1) ||
                  (state == ST_OP1  && cur_len == LEN_2) ||
                  (state == ST_OP2) ||
                  (state == ST_HOLD);

    assign buf_wr = done && run && !bus.redirect_valid;

    always_comb begin
        asm_inst         = '0;
        asm_inst.illegal = cur_illegal;
        asm_inst.len     = cur_len;
        asm_inst.opcode  = cur_op;
        asm_inst.pc      = (state == ST_OPC) ? pc : opc_pc;
        asm_inst.op_lo   = (state == ST_OP1) ? bus.mem_data : lo_q;
        asm_inst.op_hi   = (state == ST_OP2) ? bus.mem_data : hi_q;
        if (state == ST_OPC) begin
            asm_inst.op_lo = '0;
            asm_inst.op_hi = '0;
        end
    end

    always_ff @(posedge clka) begin
        if (!restart_n) begin
            state    <= ST_IDLE;
            pc       <= '0;
            opc_pc   <= '0;
            opcode_q <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
        end else if (bus.redirect_valid) begin
            pc    <= bus.redirect_pc;
            state <= run ? ST_OPC : ST_IDLE;
        end else if (!run) begin
            // Drop the partial/held instruction; it is refetched on resume.
            state <= ST_IDLE;
            if (state inside {ST_OP1, ST_OP2, ST_HOLD})
                pc <= opc_pc;
        end else begin
            case (state)
                ST_IDLE: state <= ST_OPC;
                ST_OPC: begin
                    opcode_q <= bus.mem_data;
                    lo_q     <= '0;
                    hi_q     <= '0;
                    opc_pc   <= pc;
                    pc       <= pc + PC_W'(1);
                    if (cur_len == LEN_1) state <= buf_space ? ST_OPC : ST_HOLD;
                    else                  state <= ST_OP1;
                end
                ST_OP1: begin
                    lo_q <= bus.mem_data;
                    pc   <= pc + PC_W'(1);
                    if (cur_len == LEN_2) state <= buf_space ? ST_OPC : ST_HOLD;
                    else                  state <= ST_OP2;
                end
                ST_OP2: begin
                    hi_q  <= bus.mem_data;
                    pc    <= pc + PC_W'(1);
                    state <= buf_space ? ST_OPC : ST_HOLD;
                end
                ST_HOLD: if (buf_space) state <= ST_OPC;
                default: state <= ST_IDLE;
            endcase
        end
    end

    fetch_out_buf #(.WIDTH($bits(inst_t))) u_out_buf (
        .clk       (clka),
        .rst_n     (restart_n),
        .flush     (bus.redirect_valid),
        .in_valid  (buf_wr),
        .in_ready  (buf_space),
        .in_data   (asm_inst),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (buf_inst)
    );

    assign bus.out_opcode  = buf_inst.opcode;
    assign bus.out_op_lo   = buf_inst.op_lo;
    assign bus.out_op_hi   = buf_inst.op_hi;
    assign bus.out_len     = buf_inst.len;
    assign bus.out_pc      = buf_inst.pc;
    assign bus.out_illegal = buf_inst.illegal;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [1:0] len;
        logic [7:0] pc;
        logic       illegal;
    } exp_t;

    logic clka;
    logic restart_n;
    logic run;
    logic [7:0] mem [256];

    fetch_unit_if #(.PC_W(8), .DATA_W(8)) bus ();

    fetch_unit #(.PC_W(8), .DATA_W(8)) dut (
        .clka      (clka),
        .restart_n (restart_n),
        .run       (run),
        .bus       (bus)
    );

    assign bus.mem_data = mem[bus.mem_addr];

    initial clka = 1'b0;
    always #5 clka = ~clka;

    int   checks   = 0;
    int   failures = 0;
    int   accepts  = 0;
    exp_t q [$];
    logic [7:0] next_pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: walk memory from next_pc, decoding lengths by opcode mod 4.
    function automatic void model_push();
        exp_t e;
        logic [7:0] op, a1, a2;
        op = mem[next_pc];
        a1 = next_pc + 8'd1;
        a2 = next_pc + 8'd2;
        e = '0;
        e.opcode  = op;
        e.pc      = next_pc;
        e.illegal = (op % 4 == 3);
        case (op % 4)
            1:       e.len = 2'd2;
            2:       e.len = 2'd3;
            default: e.len = 2'd1;
        endcase
        e.lo = (e.len >= 2) ? mem[a1] : 8'h00;
        e.hi = (e.len == 3) ? mem[a2] : 8'h00;
        next_pc = next_pc + 8'(e.len);
        q.push_back(e);
    endfunction

    function automatic void model_fill(input logic [7:0] pc);
        q.delete();
        next_pc = pc;
        for (int i = 0; i < 4; i++) model_push();
    endfunction

    // Monitor: checks accepted instructions against the model and buffer stability.
    exp_t cur;
    exp_t prev_data;
    logic prev_valid = 1'b0, prev_ready = 1'b0, prev_redir = 1'b0, prev_rst = 1'b0;

    always @(negedge clka) begin
        exp_t e;
        cur = {bus.out_opcode, bus.out_op_lo, bus.out_op_hi, bus.out_len, bus.out_pc, bus.out_illegal};
        if (restart_n && prev_rst && prev_valid && !prev_ready && !prev_redir) begin
            chk("hold_valid", 64'(bus.out_valid), 64'(1));
            chk("hold_stable", 64'(cur), 64'(prev_data));
        end
        if (restart_n && bus.out_valid && bus.out_ready) begin
            while (q.size() < 2) model_push();
            e = q.pop_front();
            chk("inst", 64'(cur), 64'(e));
            accepts++;
        end
        prev_data  <= cur;
        prev_valid <= bus.out_valid;
        prev_ready <= bus.out_ready;
        prev_redir <= bus.redirect_valid;
        prev_rst   <= restart_n;
    end

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic do_reset();
        restart_n          = 1'b0;
        run                = 1'b0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 8'h00;
        step();
        step();
    endtask

    task automatic release_reset();
        restart_n = 1'b1;
        model_fill(8'h00);
    endtask

    task automatic do_redirect(input logic [7:0] pc);
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        step();
        bus.redirect_valid = 1'b0;
        model_fill(pc);
    endtask

    task automatic wait_addr(input logic [7:0] target, input int max_cyc);
        logic found;
        found = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (bus.mem_addr == target) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("wait_addr", 64'(found), 64'(1));
    endtask

    initial begin
        logic [7:0] held;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h04; mem[1] = 8'h05; mem[2] = 8'hAA;
        mem[3] = 8'h06; mem[4] = 8'h34; mem[5] = 8'h12;

        // 1. reset
        do_reset();
        chk("rst_addr", 64'(bus.mem_addr), 64'(0));
        chk("rst_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_outs", 64'({bus.out_opcode, bus.out_op_lo, bus.out_op_hi, bus.out_len, bus.out_pc, bus.out_illegal}), 64'(0));
        release_reset();
        step(); step(); step();
        chk("idle_addr", 64'(bus.mem_addr), 64'(0));
        chk("idle_valid", 64'(bus.out_valid), 64'(0));

        // 2. basic stream, one byte per cycle
        run = 1'b1;
        bus.out_ready = 1'b1;
        wait_addr(8'h01, 6);
        for (int k = 2; k <= 5; k++) begin
            step();
            chk("addr_seq", 64'(bus.mem_addr), 64'(k));
        end
        repeat (4) step();

        // 3. backpressure
        bus.out_ready = 1'b0;
        repeat (4) step();
        held = bus.mem_addr;
        repeat (3) step();
        chk("hold_pc", 64'(bus.mem_addr), 64'(held));
        chk("hold_buf_valid", 64'(bus.out_valid), 64'(1));
        bus.out_ready = 1'b1;
        step();
        chk("post_release_valid", 64'(bus.out_valid), 64'(1));
        repeat (6) step();

        // 4. redirect in OP1 of the 3-byte op at pc 3
        mem[8'h10] = 8'h01; mem[8'h11] = 8'h99;
        do_reset();
        release_reset();
        run = 1'b1;
        bus.out_ready = 1'b1;
        wait_addr(8'h04, 10);
        do_redirect(8'h10);
        chk("redir_valid", 64'(bus.out_valid), 64'(0));
        chk("redir_addr", 64'(bus.mem_addr), 64'(8'h10));
        bus.out_ready = 1'b1;
        repeat (6) step();

        // 5. wrap across 0xFF
        mem[8'hFE] = 8'h02; mem[8'hFF] = 8'h11; mem[8'h00] = 8'h22;
        do_redirect(8'hFE);
        chk("wrap_fe", 64'(bus.mem_addr), 64'(8'hFE));
        bus.out_ready = 1'b1;
        step();
        chk("wrap_ff", 64'(bus.mem_addr), 64'(8'hFF));
        step();
        chk("wrap_00", 64'(bus.mem_addr), 64'(8'h00));
        repeat (8) step();

        // 6. illegal opcode, then run dropped in OP1
        mem[8'h40] = 8'h07; mem[8'h41] = 8'h02; mem[8'h42] = 8'h55; mem[8'h43] = 8'h66;
        do_redirect(8'h40);
        bus.out_ready = 1'b1;
        wait_addr(8'h42, 6);
        run = 1'b0;
        step();
        chk("rewind_addr", 64'(bus.mem_addr), 64'(8'h41));
        step(); step();
        chk("idle_hold_addr", 64'(bus.mem_addr), 64'(8'h41));
        run = 1'b1;
        repeat (8) step();

        // randomized traffic: backpressure, run toggles, redirects
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        do_redirect(8'($urandom));
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 3) begin
                do_redirect(8'($urandom));
            end else begin
                if ($urandom_range(0, 99) < 8) run = ~run;
                bus.out_ready = ($urandom_range(0, 3) != 0);
                step();
            end
        end
        run = 1'b1;
        bus.out_ready = 1'b1;
        repeat (10) step();
        chk("accepts_seen", 64'(accepts > 200), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
